program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter NBITS, default 32, instruction word width in bits.
REQ-002 Parameter CELDAS_M, default 70, number of instruction-memory words.
REQ-003 Parameter ABITS, default 7, memory address width (clog2(CELDAS_M)).
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_rx_data  input  8  byte from the UART receiver.
REQ-007 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid this cycle.
REQ-008 i_tx_done  input  1  one-cycle strobe from the UART transmitter; byte sent.
REQ-009 o_tx_data  output  8  response byte.
REQ-010 o_tx_start  output  1  one-cycle request to transmit o_tx_data.
REQ-011 o_mem_we  output  1  instruction-memory write enable.
REQ-012 o_mem_addr  output  ABITS  instruction-memory word address.
REQ-013 o_mem_data  output  NBITS  instruction-memory write data.
REQ-014 o_cpu_run  output  1  level; the MIPS core executes while high.
REQ-015 o_cpu_reset  output  1  level; holds the core in reset while loading.

Function
REQ-016 Commands: 0x4C 'L' load, 0x52 'R' run, 0x48 'H' halt; all other bytes received in IDLE are ignored.
REQ-017 FSM states: IDLE, COUNT, WORD, WRITE, CHECK, ACK, ACKWAIT, RUN.
REQ-018 IDLE + 'L' -> COUNT, and o_cpu_reset asserts on the next cycle.
REQ-019 COUNT: the next byte is N; 1 <= N <= CELDAS_M -> WORD; N = 0 or N > CELDAS_M -> ACK with NAK (0x15).
REQ-020 WORD: 4 bytes per word, MSB first, shifted into a 32-bit assembly register; after the 4th byte -> WRITE.
REQ-021 WRITE: o_mem_we high for exactly one cycle, with the address counter (0-based) and the assembled word; counter increments; -> CHECK when N words are done, else -> WORD.
REQ-022 Without CHECKSUM_EN, CHECK passes through immediately to ACK with ACK (0x06).
REQ-023 ACK: o_tx_start pulses for one cycle with the response byte -> ACKWAIT; ACKWAIT -> IDLE on i_tx_done.
REQ-024 In IDLE, 'R' sets o_cpu_run = 1, clears o_cpu_reset, sends 0x06, and the FSM -> RUN after the ACK handshake; o_cpu_run holds.
REQ-025 In RUN, 'H' clears o_cpu_run and sends 0x06 -> IDLE; all other bytes are ignored.
REQ-026 i_rx_valid during WRITE, ACK or ACKWAIT is dropped; the byte count does not advance.
REQ-027 A load of exactly CELDAS_M words writes the last address CELDAS_M-1; the address never wraps.
REQ-028 An 'R' received before any successful load is accepted; memory contents are whatever was written last.

Reset
REQ-029 Reset forces state IDLE; o_mem_we, o_tx_start and o_cpu_run = 0; o_cpu_reset = 1; o_tx_data, o_mem_addr and o_mem_data = 0; counters and checksum = 0.
REQ-030 Reset mid-load abandons the transfer with no response byte; already-written words stay in memory.

Configuration
REQ-031 Macro PROGRAM_LOADER_CHECKSUM_EN: when defined, the block expects one extra byte after the last word in CHECK, equal to the XOR of all 4N data bytes.
  - Match -> 0x06; mismatch -> 0x15.
  - Words are written regardless of the result.
  - When undefined: no checksum byte and no XOR logic.

Structure
REQ-032 A shared package loader_pkg holds:
  - the FSM state enum;
  - the command constants CMD_LOAD, CMD_RUN, CMD_HALT;
  - the response constants RSP_ACK, RSP_NAK.
REQ-033 One sub-module, word_assembler: an 8-to-32 shift register with a byte counter and a word_valid strobe.

Verification
REQ-034 'L', N=2, bytes 00 00 00 01 DE AD BE EF -> writes at addr 0 = 0x00000001 and addr 1 = 0xDEADBEEF, each one cycle; then tx 0x06.
REQ-035 'L', N=0 -> tx 0x15, no o_mem_we, back to IDLE; same result with N=71.
REQ-036 'R' then 'H' -> o_cpu_run rises after 'R' and falls after 'H'; two 0x06 responses; the 'L' byte sent while in RUN is ignored.
REQ-037 Reset asserted after 2 of 4 bytes of word 0 -> IDLE and o_cpu_reset = 1 with no tx; a fresh 'L' N=1 then succeeds.
REQ-038 With CHECKSUM_EN, N=1, data 11 22 33 44, checksum 0x44 -> 0x06; checksum 0x00 -> 0x15, word still written.
REQ-039 Load N=70 words of incrementing data -> last write at addr 69; o_mem_addr never reaches 70.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM states, command and
// response bytes, and the word-count range check.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        WORD,
        WRITE,
        CHECK,
        ACK,
        ACKWAIT,
        RUN
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    // A load must carry at least one word and must fit in instruction memory.
    function automatic logic count_in_range(input logic [7:0] n, input int max_words);
        return (n != 8'd0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word shift register for the program loader. Bytes arrive MSB
// first; word_valid strobes combinationally with the last byte of a word, so
// the assembled word is present in 'word' on the following cycle.
module word_assembler
    import loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [NBITS-1:0] word,
    output logic             word_valid
);

    logic [1:0] byte_cnt;

    assign word_valid = byte_valid && (byte_cnt == 2'd3);

    // Shift each accepted byte in from the right and count bytes per word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= {word[NBITS-9:0], byte_in};
        end
    end

endmodule

// File: rtl/program_loader.sv
// UART-driven instruction-memory loader and run/halt controller for a MIPS
// core. Commands: 'L' N <4N bytes> loads N words, 'R' starts the core, 'H'
// halts it. Every accepted command is answered with one ACK/NAK byte.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte to each load.
module program_loader
    import loader_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int CELDAS_M = 70,
    parameter int ABITS    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_tx_done,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_mem_we,
    output logic [ABITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_data,
    output logic             o_cpu_run,
    output logic             o_cpu_reset
);

    state_t           state;
    state_t           next_state;
    logic [7:0]       words_left;
    logic [ABITS-1:0] addr;
    logic [7:0]       rsp;
    logic             go_run;
    logic             cpu_run;
    logic             cpu_reset;
    logic             asm_clear;
    logic             asm_valid;
    logic             word_valid;
    logic [NBITS-1:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // Bytes reach the assembler only while collecting words; the byte
    // counter is re-aligned while the word count is being received.
    assign asm_clear = (state == COUNT);
    assign asm_valid = (state == WORD) && i_rx_valid;

    word_assembler #(
        .NBITS(NBITS)
    ) u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_in    (i_rx_data),
        .byte_valid (asm_valid),
        .word       (word),
        .word_valid (word_valid)
    );

    assign o_mem_we    = (state == WRITE);
    assign o_tx_start  = (state == ACK);
    assign o_tx_data   = rsp;
    assign o_mem_addr  = addr;
    assign o_mem_data  = word;
    assign o_cpu_run   = cpu_run;
    assign o_cpu_reset = cpu_reset;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; bytes arriving in WRITE/ACK/ACKWAIT fall through untouched.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        next_state = COUNT;
                    end else if (i_rx_data == CMD_RUN) begin
                        next_state = ACK;
                    end
                end
            end
            COUNT: begin
                if (i_rx_valid) begin
                    next_state = count_in_range(i_rx_data, CELDAS_M) ? WORD : ACK;
                end
            end
            WORD: begin
                if (word_valid) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (words_left == 8'd1) ? CHECK : WORD;
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (i_rx_valid) begin
                    next_state = ACK;
                end
`else
                next_state = ACK;
`endif
            end
            ACK: begin
                next_state = ACKWAIT;
            end
            ACKWAIT: begin
                if (i_tx_done) begin
                    next_state = go_run ? RUN : IDLE;
                end
            end
            RUN: begin
                if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
                    next_state = ACK;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Load counters, response byte and CPU control levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_left <= '0;
            addr       <= '0;
            rsp        <= '0;
            go_run     <= 1'b0;
            cpu_run    <= 1'b0;
            cpu_reset  <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
                        cpu_reset <= 1'b1;
                        go_run    <= 1'b0;
                        addr      <= '0;
                    end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
                        cpu_run   <= 1'b1;
                        cpu_reset <= 1'b0;
                        go_run    <= 1'b1;
                        rsp       <= RSP_ACK;
                    end
                end
                COUNT: begin
                    if (i_rx_valid) begin
                        words_left <= i_rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                        if (!count_in_range(i_rx_data, CELDAS_M)) begin
                            rsp <= RSP_NAK;
                        end
                    end
                end
                WORD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (i_rx_valid) begin
                        csum <= csum ^ i_rx_data;
                    end
`endif
                end
                WRITE: begin
                    // The address holds on the last word so it never steps past N-1.
                    words_left <= words_left - 8'd1;
                    if (words_left != 8'd1) begin
                        addr <= addr + ABITS'(1);
                    end
                end
                CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (i_rx_valid) begin
                        rsp <= (i_rx_data == csum) ? RSP_ACK : RSP_NAK;
                    end
`else
                    rsp <= RSP_ACK;
`endif
                end
                RUN: begin
                    if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
                        cpu_run <= 1'b0;
                        go_run  <= 1'b0;
                        rsp     <= RSP_ACK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes
// and response bytes into a queue; a monitor pops and compares them whenever
// the DUT strobes o_mem_we or o_tx_start.
module tb_program_loader;
    import loader_pkg::*;

    localparam int NBITS    = 32;
    localparam int CELDAS_M = 70;
    localparam int ABITS    = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             i_tx_done;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             o_mem_we;
    logic [ABITS-1:0] o_mem_addr;
    logic [NBITS-1:0] o_mem_data;
    logic             o_cpu_run;
    logic             o_cpu_reset;

    typedef struct packed {
        logic             is_tx;
        logic [ABITS-1:0] addr;
        logic [NBITS-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          tx_cnt   = 0;
    int          max_addr = -1;
    int          c0;
    logic [31:0] ld_words [0:CELDAS_M-1];

    always #5 clk = ~clk;

    program_loader #(
        .NBITS(NBITS),
        .CELDAS_M(CELDAS_M),
        .ABITS(ABITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_cpu_run   (o_cpu_run),
        .o_cpu_reset (o_cpu_reset)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_t e;
        e.is_tx = 1'b0;
        e.addr  = ABITS'(a);
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_t e;
        e.is_tx = 1'b1;
        e.addr  = '0;
        e.data  = {24'd0, b};
        exp_q.push_back(e);
    endtask

    // One byte strobe followed by two quiet cycles.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge clk);
    endtask

    // Wait (bounded) for a response byte beyond count 'start', then let the handshake finish.
    task automatic wait_resp(input int start);
        int k;
        k = 0;
        while ((tx_cnt == start) && (k < 400)) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (tx_cnt == start) begin
            n_fail++;
            $display("FAIL resp_timeout: got no response byte, required one within 400 cycles");
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic send_load(input int n, input bit bad_csum);
        int   start;
        logic [7:0] b;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        start = tx_cnt;
        for (int i = 0; i < n; i++) push_wr(i, ld_words[i]);
        if (bad_csum) push_tx(RSP_NAK);
        else          push_tx(RSP_ACK);
        send_byte(CMD_LOAD);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int j = 3; j >= 0; j--) begin
                b = ld_words[i][8*j +: 8];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                x = x ^ b;
`endif
                send_byte(b);
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? 8'h00 : x);
`endif
        wait_resp(start);
    endtask

    task automatic send_bad_count(input logic [7:0] n);
        int start;
        start = tx_cnt;
        push_tx(RSP_NAK);
        send_byte(CMD_LOAD);
        send_byte(n);
        wait_resp(start);
    endtask

    // Monitor: every write or transmit strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_mem_we) begin
                if (int'(o_mem_addr) > max_addr) max_addr = int'(o_mem_addr);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr=%0d data=%h, required no write", o_mem_addr, o_mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_tx || (mon_e.addr !== o_mem_addr) || (mon_e.data !== o_mem_data)) begin
                        n_fail++;
                        $display("FAIL mem_write: got addr=%0d data=%h, required tx=%0d addr=%0d data=%h",
                                 o_mem_addr, o_mem_data, mon_e.is_tx, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (o_tx_start) begin
                tx_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h, required no transmit", o_tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_tx || (mon_e.data[7:0] !== o_tx_data)) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %h, required tx=%0d byte %h",
                                 o_tx_data, mon_e.is_tx, mon_e.data[7:0]);
                    end
                end
            end
        end
    end

    // UART transmitter model: reports completion a few cycles after each start.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                repeat (3) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_cpu_reset", o_cpu_reset, 1);
        check("rst_cpu_run",   o_cpu_run,   0);
        check("rst_mem_we",    o_mem_we,    0);
        check("rst_tx_start",  o_tx_start,  0);
        check("rst_mem_addr",  o_mem_addr,  0);
        check("rst_mem_data",  o_mem_data,  0);
        check("rst_tx_data",   o_tx_data,   0);
        reset = 1'b0;

        // Unknown bytes and 'H' in IDLE produce nothing.
        send_byte(8'h00);
        send_byte(8'h41);
        send_byte(CMD_HALT);
        repeat (5) @(negedge clk);
        check("idle_ignore_cpu_run", o_cpu_run, 0);

        // Two-word load.
        ld_words[0] = 32'h0000_0001;
        ld_words[1] = 32'hDEAD_BEEF;
        send_load(2, 1'b0);
        check("load2_cpu_reset", o_cpu_reset, 1);
        check("load2_cpu_run",   o_cpu_run,   0);

        // Out-of-range counts are refused.
        send_bad_count(8'd0);
        send_bad_count(8'd71);

        // Run, ignored 'L' while running, then halt.
        c0 = tx_cnt;
        push_tx(RSP_ACK);
        send_byte(CMD_RUN);
        wait_resp(c0);
        check("run_cpu_run",   o_cpu_run,   1);
        check("run_cpu_reset", o_cpu_reset, 0);
        send_byte(CMD_LOAD);
        send_byte(8'd1);
        repeat (10) @(negedge clk);
        check("run_ignore_cpu_run",   o_cpu_run,   1);
        check("run_ignore_cpu_reset", o_cpu_reset, 0);
        c0 = tx_cnt;
        push_tx(RSP_ACK);
        send_byte(CMD_HALT);
        wait_resp(c0);
        check("halt_cpu_run", o_cpu_run, 0);

        // Reset in the middle of word 0.
        send_byte(CMD_LOAD);
        send_byte(8'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("load_sets_cpu_reset", o_cpu_reset, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_cpu_reset", o_cpu_reset, 1);
        check("midrst_mem_addr",  o_mem_addr,  0);
        check("midrst_tx_start",  o_tx_start,  0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        ld_words[0] = 32'hCAFE_F00D;
        send_load(1, 1'b0);

        // Full-memory load.
        for (int i = 0; i < CELDAS_M; i++) ld_words[i] = 32'h1000_0000 + 32'(i);
        max_addr = -1;
        send_load(CELDAS_M, 1'b0);
        check("full_load_max_addr", max_addr, CELDAS_M - 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ld_words[0] = 32'h1122_3344;
        send_load(1, 1'b0);
        send_load(1, 1'b1);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
